// File: rtl/sum_series_pkg.sv
// Shared types and constants for the streaming series accumulator and its fp32 adder.
package sum_series_pkg;

    localparam int FP_W      = 32;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int GUARD_W   = 3;
    localparam int MANT_W    = FP_FRAC_W + 1 + GUARD_W;

    localparam logic [FP_W-1:0]     FP_QNAN    = 32'h7FC00000;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {IDLE, RUN, ALIGN, ADD, NORM, DONE} state_t;

    typedef enum logic {MODE_FP = 1'b0, MODE_INT = 1'b1} mode_t;

    typedef struct packed {
        logic                special;
        logic                special_inv;
        logic [FP_W-1:0]     special_val;
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic                eff_sub;
        logic [MANT_W-1:0]   mant_big;
        logic [MANT_W-1:0]   mant_small;
    } align_t;

    typedef struct packed {
        logic                special;
        logic                special_inv;
        logic [FP_W-1:0]     special_val;
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [MANT_W:0]     mant;
    } sum_t;

    function automatic logic [4:0] lead_zeros(input logic [MANT_W-1:0] v);
        lead_zeros = 5'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (v[i]) lead_zeros = 5'(MANT_W - 1 - i);
        end
    endfunction

endpackage

// File: rtl/fp32_add_unit.sv
// Combinational fp32 adder split into align, add and normalise slices;
// the parent registers between slices so each takes one cycle.
module fp32_add_unit
    import sum_series_pkg::*;
(
    input  logic [FP_W-1:0] op_a,
    input  logic [FP_W-1:0] op_b,
    output align_t          align_out,
    input  align_t          align_in,
    output sum_t            add_out,
    input  sum_t            add_in,
    output logic [FP_W-1:0] norm_result,
    output logic            norm_overflow,
    output logic            norm_invalid
);

    logic                 sign_a, sign_b;
    logic [FP_EXP_W-1:0]  exp_a, exp_b;
    logic [FP_FRAC_W-1:0] frac_a, frac_b;
    logic                 a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [FP_W-2:0]      mag_a, mag_b;
    logic [FP_FRAC_W:0]   man_a, man_b;

    assign {sign_a, exp_a, frac_a} = op_a;
    assign {sign_b, exp_b, frac_b} = op_b;
    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_nan  = (exp_a == FP_EXP_MAX) && (frac_a != '0);
    assign b_nan  = (exp_b == FP_EXP_MAX) && (frac_b != '0);
    assign a_inf  = (exp_a == FP_EXP_MAX) && (frac_a == '0);
    assign b_inf  = (exp_b == FP_EXP_MAX) && (frac_b == '0);
    // Exponent-zero operands are flushed: no hidden bit and no fraction.
    assign mag_a  = a_zero ? '0 : op_a[FP_W-2:0];
    assign mag_b  = b_zero ? '0 : op_b[FP_W-2:0];
    assign man_a  = a_zero ? '0 : {1'b1, frac_a};
    assign man_b  = b_zero ? '0 : {1'b1, frac_b};
    assign a_big  = (mag_a >= mag_b);

    logic [FP_EXP_W-1:0] exp_big, exp_small, shift_amt;
    logic [MANT_W-1:0]   small_ext, shifted;
    logic                sticky;

    always_comb begin
        align_out = '0;
        exp_big   = a_big ? exp_a : exp_b;
        exp_small = a_big ? exp_b : exp_a;
        small_ext = {(a_big ? man_b : man_a), {GUARD_W{1'b0}}};
        shift_amt = exp_big - exp_small;
        if (shift_amt >= FP_EXP_W'(MANT_W)) begin
            shifted = '0;
            sticky  = |small_ext;
        end else begin
            shifted = small_ext >> shift_amt;
            sticky  = |(small_ext & ~({MANT_W{1'b1}} << shift_amt));
        end
        align_out.sign       = a_big ? sign_a : sign_b;
        align_out.exp        = exp_big;
        align_out.eff_sub    = sign_a ^ sign_b;
        align_out.mant_big   = {(a_big ? man_a : man_b), {GUARD_W{1'b0}}};
        align_out.mant_small = {shifted[MANT_W-1:1], shifted[0] | sticky};
        if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b))) begin
            align_out.special     = 1'b1;
            align_out.special_inv = 1'b1;
            align_out.special_val = FP_QNAN;
        end else if (a_inf) begin
            align_out.special     = 1'b1;
            align_out.special_val = op_a;
        end else if (b_inf) begin
            align_out.special     = 1'b1;
            align_out.special_val = op_b;
        end
    end

    always_comb begin
        add_out             = '0;
        add_out.special     = align_in.special;
        add_out.special_inv = align_in.special_inv;
        add_out.special_val = align_in.special_val;
        add_out.sign        = align_in.sign;
        add_out.exp         = align_in.exp;
        if (align_in.eff_sub) add_out.mant = {1'b0, align_in.mant_big} - {1'b0, align_in.mant_small};
        else                  add_out.mant = {1'b0, align_in.mant_big} + {1'b0, align_in.mant_small};
    end

    logic [4:0]        lz;
    logic [MANT_W-1:0] norm_mant;
    logic signed [9:0] exp_res;
    logic              unused_norm;

    always_comb begin
        norm_result   = '0;
        norm_overflow = 1'b0;
        norm_invalid  = 1'b0;
        lz            = '0;
        norm_mant     = '0;
        exp_res       = '0;
        if (add_in.special) begin
            norm_result  = add_in.special_val;
            norm_invalid = add_in.special_inv;
        end else if (add_in.mant != '0) begin
            if (add_in.mant[MANT_W]) begin
                norm_mant = add_in.mant[MANT_W:1];
                exp_res   = $signed({2'b00, add_in.exp}) + 10'sd1;
            end else begin
                lz        = lead_zeros(add_in.mant[MANT_W-1:0]);
                norm_mant = add_in.mant[MANT_W-1:0] << lz;
                exp_res   = $signed({2'b00, add_in.exp}) - $signed({5'b00000, lz});
            end
            // Truncating rounding: guard bits are simply dropped; underflow flushes to +0.
            if (exp_res >= 10'sd255) begin
                norm_result   = {add_in.sign, FP_EXP_MAX, {FP_FRAC_W{1'b0}}};
                norm_overflow = 1'b1;
            end else if (exp_res > 10'sd0) begin
                norm_result = {add_in.sign, exp_res[FP_EXP_W-1:0], norm_mant[MANT_W-2 -: FP_FRAC_W]};
            end
        end
    end

    assign unused_norm = ^{norm_mant[MANT_W-1], norm_mant[GUARD_W-1:0]};

endmodule

// File: rtl/sum_series_stream.sv
// Streaming series accumulator: sums count elements as uint32 (one per cycle)
// or fp32 (one per four cycles through a registered align/add/normalise pipe).
module sum_series_stream
    import sum_series_pkg::*;
#(
    parameter int MAX_N = 1024,
    parameter int CNT_W = $clog2(MAX_N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      sum_output,
    output logic             done,
    output logic             busy,
    output logic             overflow,
    output logic             invalid
);

    state_t           state_q, state_d;
    mode_t            mode_q;
    logic [CNT_W-1:0] count_q, elem_cnt_q, elem_cnt_inc;
    logic [31:0]      acc_q, b_q, result_q;
    logic             overflow_q, invalid_q, accept;
    logic [32:0]      int_sum;
    align_t           align_d, align_q;
    sum_t             add_d, add_q;
    logic [31:0]      norm_result;
    logic             norm_overflow, norm_invalid;

    fp32_add_unit u_fp_add (
        .op_a          (acc_q),
        .op_b          (b_q),
        .align_out     (align_d),
        .align_in      (align_q),
        .add_out       (add_d),
        .add_in        (add_q),
        .norm_result   (norm_result),
        .norm_overflow (norm_overflow),
        .norm_invalid  (norm_invalid)
    );

    assign accept       = in_valid && in_ready;
    assign elem_cnt_inc = elem_cnt_q + CNT_W'(1);
    assign int_sum      = {1'b0, acc_q} + {1'b0, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy = start;
                if (start) state_d = (count == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (mode_q == MODE_FP)           state_d = ALIGN;
                    else if (elem_cnt_inc == count_q) state_d = DONE;
                end
            end
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = (elem_cnt_q == count_q) ? DONE : RUN;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= MODE_FP;
            count_q    <= '0;
            elem_cnt_q <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            invalid_q  <= 1'b0;
            align_q    <= '0;
            add_q      <= '0;
        end else begin
            // NOTE: non-blocking in clocked blocks so every register samples pre-edge values.
            if (state_q == IDLE && start) begin
                mode_q     <= mode_t'(mode);
                count_q    <= (count > CNT_W'(MAX_N)) ? CNT_W'(MAX_N) : count;
                elem_cnt_q <= '0;
                acc_q      <= '0;
                overflow_q <= 1'b0;
                invalid_q  <= 1'b0;
            end
            if (accept) begin
                elem_cnt_q <= elem_cnt_inc;
                if (mode_q == MODE_INT) begin
                    acc_q      <= int_sum[31:0];
                    overflow_q <= overflow_q | int_sum[32];
                end else begin
                    b_q <= in_data;
                end
            end
            if (state_q == ALIGN) align_q <= align_d;
            if (state_q == ADD)   add_q   <= add_d;
            if (state_q == NORM) begin
                acc_q      <= norm_result;
                overflow_q <= overflow_q | norm_overflow;
                invalid_q  <= invalid_q | norm_invalid;
            end
            if (state_q == DONE) result_q <= acc_q;
        end
    end

    // The final sum is visible during the done cycle and held afterwards.
    assign sum_output = (state_q == DONE) ? acc_q : result_q;
    assign overflow   = overflow_q;
    assign invalid    = invalid_q;

endmodule
